tdm_lif_array: RTL
==================

TDM_LIF_ARRAY -- requirements
Module: tdm_lif_array

Interface
REQ-001 SHALL have parameter NEURON_COUNT, default 500: number of time-multiplexed neurons; SHALL be > PIPE_DEPTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS width of membrane, stimulus and threshold values.
REQ-003 SHALL have parameter FRAC_BITS, default 12: fractional bits (1.0 = 4096).
REQ-004 SHALL have parameter PIPE_DEPTH, default 5: cycles from state read to writeback, >= 2.
REQ-005 SHALL have parameter LEAK_SHIFT, default 4: leak term = v >>> LEAK_SHIFT (arithmetic shift).
REQ-006 SHALL have parameter REFRAC_SWEEPS, default 2: sweeps a neuron is held after a spike.
REQ-007 SHALL have parameters V_TH, default 8192, and V_RESET, default 0: firing threshold and post-spike value.
REQ-008 SHALL have parameter FIFO_DEPTH, default 16: spike event FIFO entries, power of 2.
REQ-009 clk  in  1  clock; all state updates on rising edge.
REQ-010 rst  in  1  reset, synchronous, active-low.
REQ-011 en  in  1  high: issue one neuron per cycle; low: issue bubbles.
REQ-012 i_global  in  DATA_WIDTH  signed stimulus added to every neuron.
REQ-013 stim_we / stim_addr / stim_data  in  1 / clog2(NEURON_COUNT) / DATA_WIDTH  per-neuron stimulus register write port.
REQ-014 busy  out  1  high during INIT.
REQ-015 wr_valid / ptr_write / core_v_out  out  1 / clog2(NEURON_COUNT) / DATA_WIDTH  writeback strobe, neuron id, new membrane value.
REQ-016 sweep_done  out  1  one-cycle pulse on writeback of neuron NEURON_COUNT-1; sweep_count  out  32  completed sweeps.
REQ-017 spike_valid / spike_ready / spike_id / spike_sweep  out / in / out / out  1 / 1 / clog2(NEURON_COUNT) / 32  spike event stream, valid-ready.
REQ-018 spike_overflow  out  1  sticky: an event was dropped.

Function
REQ-019 FSM states INIT, RUN; INIT clears v (to V_RESET), stim and refractory memories, one address per cycle for NEURON_COUNT cycles, then RUN.
REQ-020 In INIT, en and stim_we SHALL be ignored, wr_valid SHALL stay low.
REQ-021 In RUN with en=1, read pointer SHALL issue neurons 0..NEURON_COUNT-1 ascending, wrapping to 0; en=0 freezes pointer, in-flight entries still complete.
REQ-022 Writeback of a neuron read in cycle t SHALL occur in cycle t+PIPE_DEPTH (wr_valid=1, ptr_write, core_v_out).
REQ-023 Input i = sat(i_global + stim[n]), sum computed in DATA_WIDTH+1 bits, saturated to signed DATA_WIDTH.
REQ-024 If refrac[n]>0: v_next=V_RESET, refrac[n] decremented, no spike.
REQ-025 Else v_next = sat(v - (v >>> LEAK_SHIFT) + i), computed in DATA_WIDTH+2 bits, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 If v_next >= V_TH (signed): spike; stored and output value = V_RESET; refrac[n] = REFRAC_SWEEPS.
REQ-027 stim write to the address being read in the same cycle: read SHALL return the old value; new value used next sweep.
REQ-028 Spike SHALL push {id, sweep_count} into FIFO in writeback cycle; spike_valid earliest next cycle.
REQ-029 Push with FIFO full SHALL drop the new event and set spike_overflow; simultaneous pop and push when full SHALL accept both.
REQ-030 FIFO pops when spike_valid && spike_ready; spike_id/spike_sweep stable while spike_valid && !spike_ready.
REQ-031 sweep_count SHALL increment in the sweep_done cycle, wrap at 2^32.

Reset
REQ-032 rst=0 at any edge (including mid-sweep or mid-INIT) SHALL: enter INIT at address 0, flush pipeline and FIFO, clear busy's predecessor state; outputs: busy=1, wr_valid=0, ptr_write=0, core_v_out=0, sweep_done=0, sweep_count=0, spike_valid=0, spike_id=0, spike_sweep=0, spike_overflow=0.
REQ-033 Pipeline entries issued before reset SHALL NOT write back after reset.

Verification
REQ-034 Reset, wait: busy high exactly NEURON_COUNT cycles after rst rises, then all first-sweep reads return v=0, stim=0.
REQ-035 i_global=4096, en=1, defaults: neuron 0 core_v_out per sweep 4096, 7936, spike(0), 0, 0, 4096, 7936, spike(0); spike period 5 sweeps, spike_sweep 2, 7, ...
REQ-036 stim_data=32767 on neuron 3, i_global=32767: i saturates to 32767; v never exceeds 32767 pre-threshold, neuron 3 spikes sweep 0.
REQ-037 spike_ready=0, all neurons spiking: FIFO holds 16 events (ids 0..15), spike_overflow sets on 17th, data stable until ready.
REQ-038 en toggled 0 for 10 cycles mid-sweep: pointer holds, in-flight writebacks complete, sweep_count unaffected except completion timing; stim write collision per REQ-027.
REQ-039 rst pulsed mid-sweep with spikes queued: FIFO empty, no stale wr_valid, INIT restarts at 0.

Source files
------------

// File: rtl/tdm_lif_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array.
// One neuron is read per cycle, updated combinationally, carried down a
// PIPE_DEPTH-deep pipeline and written back; spikes go to a valid/ready FIFO.
module tdm_lif_array #(
  parameter int NEURON_COUNT  = 500,
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_BITS     = 12,
  parameter int PIPE_DEPTH    = 5,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRAC_SWEEPS = 2,
  parameter int V_TH          = 8192,
  parameter int V_RESET       = 0,
  parameter int FIFO_DEPTH    = 16,
  localparam int AW = $clog2(NEURON_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] i_global,
  input  logic                  stim_we,
  input  logic [AW-1:0]         stim_addr,
  input  logic [DATA_WIDTH-1:0] stim_data,
  output logic                  busy,
  output logic                  wr_valid,
  output logic [AW-1:0]         ptr_write,
  output logic [DATA_WIDTH-1:0] core_v_out,
  output logic                  sweep_done,
  output logic [31:0]           sweep_count,
  output logic                  spike_valid,
  input  logic                  spike_ready,
  output logic [AW-1:0]         spike_id,
  output logic [31:0]           spike_sweep,
  output logic                  spike_overflow
);
  localparam int DW  = DATA_WIDTH;
  localparam int RW  = (REFRAC_SWEEPS > 0) ? $clog2(REFRAC_SWEEPS + 1) : 1;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(NEURON_COUNT - 1);
  localparam logic signed [DW-1:0] VTH  = DW'(V_TH);
  localparam logic signed [DW-1:0] VRST = DW'(V_RESET);
  localparam logic signed [DW+1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SMIN = {3'b111, {(DW-1){1'b0}}};
  // an inconsistent configuration never issues work
  localparam bit PARAMS_OK = (FRAC_BITS < DATA_WIDTH) && (PIPE_DEPTH >= 2) &&
                             (NEURON_COUNT > PIPE_DEPTH);

  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic [AW-1:0] id;
    logic [DW-1:0] v;
    logic [RW-1:0] refrac;
    logic          spike;
  } pipe_t;
  typedef struct packed {
    logic [AW-1:0] id;
    logic [31:0]   sweep;
  } evt_t;

  state_t state, state_nx;
  logic [AW-1:0] init_addr, rd_ptr;
  logic issue;

  logic [DW-1:0] v_mem      [NEURON_COUNT];
  logic [DW-1:0] stim_mem   [NEURON_COUNT];
  logic [RW-1:0] refrac_mem [NEURON_COUNT];

  logic [PIPE_DEPTH:1] vld_pipe;
  pipe_t pipe [PIPE_DEPTH:1];
  pipe_t s0;

  logic [DW-1:0] v_rd, st_rd;
  logic [RW-1:0] rf_rd;
  logic [DW:0] i_sum;
  logic signed [DW-1:0] i_sat, v_sat;
  logic signed [DW+1:0] vx, sum;

  evt_t fifo_mem [FIFO_DEPTH];
  evt_t head;
  logic [FAW-1:0] f_wr, f_rd;
  logic [FAW:0] f_cnt;
  logic push, pop, full, acc;

  // state register
  always_ff @(posedge clk) state <= rst ? state_nx : INIT;

  // next state and issue control
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      INIT: if (init_addr == LAST) state_nx = RUN;
      RUN:  issue = en && PARAMS_OK;
      default: state_nx = INIT;
    endcase
  end

  // clear address walker and read pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      init_addr <= '0;
      rd_ptr    <= '0;
    end else begin
      if (state == INIT) init_addr <= (init_addr == LAST) ? '0 : init_addr + AW'(1);
      if (issue) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
    end
  end

  // state memories: INIT clear, otherwise writeback and stimulus writes
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        v_mem[init_addr]      <= VRST;
        stim_mem[init_addr]   <= '0;
        refrac_mem[init_addr] <= '0;
      end else begin
        if (wr_valid) begin
          v_mem[ptr_write]      <= pipe[PIPE_DEPTH].v;
          refrac_mem[ptr_write] <= pipe[PIPE_DEPTH].refrac;
        end
        if (stim_we && (int'(stim_addr) < NEURON_COUNT)) stim_mem[stim_addr] <= stim_data;
      end
    end
  end

  // stage 0: read state, saturate input current, leak/integrate/fire
  always_comb begin
    s0    = '0;
    v_rd  = v_mem[rd_ptr];
    st_rd = stim_mem[rd_ptr];
    rf_rd = refrac_mem[rd_ptr];
    i_sum = {i_global[DW-1], i_global} + {st_rd[DW-1], st_rd};
    if (i_sum[DW] != i_sum[DW-1]) i_sat = i_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else                          i_sat = i_sum[DW-1:0];
    vx  = {{2{v_rd[DW-1]}}, v_rd};
    sum = vx - (vx >>> LEAK_SHIFT) + {{2{i_sat[DW-1]}}, i_sat};
    if (sum > SMAX)      v_sat = SMAX[DW-1:0];
    else if (sum < SMIN) v_sat = SMIN[DW-1:0];
    else                 v_sat = sum[DW-1:0];
    s0.id = rd_ptr;
    if (rf_rd != '0) begin
      s0.v      = VRST;
      s0.refrac = rf_rd - RW'(1);
    end else if (v_sat >= VTH) begin
      s0.v      = VRST;
      s0.refrac = RW'(REFRAC_SWEEPS);
      s0.spike  = 1'b1;
    end else begin
      s0.v = v_sat;
    end
  end

  // writeback pipeline; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int k = 1; k <= PIPE_DEPTH; k++) pipe[k] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_DEPTH-1:1], issue};
      pipe[1]  <= s0;
      for (int k = 2; k <= PIPE_DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign busy       = (state == INIT);
  assign wr_valid   = vld_pipe[PIPE_DEPTH];
  assign ptr_write  = pipe[PIPE_DEPTH].id;
  assign core_v_out = pipe[PIPE_DEPTH].v;
  assign sweep_done = wr_valid && (ptr_write == LAST);

  // completed sweep counter
  always_ff @(posedge clk) begin
    if (!rst) sweep_count <= '0;
    else if (sweep_done) sweep_count <= sweep_count + 32'd1;
  end

  // spike FIFO: a full FIFO still accepts a push when it pops the same cycle
  assign push = wr_valid && pipe[PIPE_DEPTH].spike;
  assign pop  = spike_valid && spike_ready;
  assign full = (f_cnt == (FAW+1)'(FIFO_DEPTH));
  assign acc  = push && (!full || pop);

  // FIFO storage
  always_ff @(posedge clk) if (acc) fifo_mem[f_wr] <= '{id: ptr_write, sweep: sweep_count};

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      f_wr <= '0;
      f_rd <= '0;
      f_cnt <= '0;
      spike_overflow <= 1'b0;
    end else begin
      if (acc) f_wr <= f_wr + FAW'(1);
      if (pop) f_rd <= f_rd + FAW'(1);
      if (acc && !pop)      f_cnt <= f_cnt + (FAW+1)'(1);
      else if (!acc && pop) f_cnt <= f_cnt - (FAW+1)'(1);
      if (push && !acc) spike_overflow <= 1'b1;
    end
  end

  assign head        = fifo_mem[f_rd];
  assign spike_valid = (f_cnt != '0);
  assign spike_id    = spike_valid ? head.id : '0;
  assign spike_sweep = spike_valid ? head.sweep : '0;
endmodule
